cyclic_lamp_seq: RTL and testbench

- Parametrised Moore-FSM lamp sequencer; next generation of the fixed 3-lamp cyclic lamp.
- Drives a one-hot lamp vector of N_LAMPS bits, holding each lamp for DWELL cycles.
- Adds enable, direction, hold/pause and a per-revolution wrap pulse.
- Sits directly behind board LED/lamp outputs; all outputs are registered.

---
 rtl/cyclic_lamp_seq_if.sv | 32 +++
 rtl/cyclic_lamp_seq.sv | 126 ++++++++++++
 tb/tb_cyclic_lamp_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cyclic_lamp_seq_if.sv
// Lamp sequencer control/status bundle: en/dir/hold in, one-hot lamp, index and wrap out.
// blink exists only when CYCLIC_LAMP_BLINK_EN is defined.
interface cyclic_lamp_seq_if #(
   parameter int N_LAMPS = 3,
   parameter int IDX_W   = $clog2(N_LAMPS)
);
   logic               en;
   logic               dir;
   logic               hold;
`ifdef CYCLIC_LAMP_BLINK_EN
   logic               blink;
`endif
   logic [N_LAMPS-1:0] light;
   logic [IDX_W-1:0]   idx;
   logic               wrap;

   modport master (
      output en, dir, hold,
`ifdef CYCLIC_LAMP_BLINK_EN
      output blink,
`endif
      input  light, idx, wrap
   );

   modport slave (
      input  en, dir, hold,
`ifdef CYCLIC_LAMP_BLINK_EN
      input  blink,
`endif
      output light, idx, wrap
   );
endinterface

// File: rtl/cyclic_lamp_seq.sv
// Cyclic one-hot lamp sequencer with enable, direction, hold and per-revolution wrap pulse.
// Optional flashing of the lit lamp is compiled in with CYCLIC_LAMP_BLINK_EN.
//
// state   | meaning
// S_IDLE  | lamps off, idx/counter cleared, waiting for en
// S_RUN   | lamp idx lit, dwell counter running
// S_PAUSE | hold asserted, lamp/idx/counter frozen
module cyclic_lamp_seq #(
   parameter int N_LAMPS = 3,
   parameter int DWELL   = 4,
   parameter int IDX_W   = $clog2(N_LAMPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   cyclic_lamp_seq_if.slave lamp
);
   localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_LAMPS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N_LAMPS-1:0] light_q, light_d;
   logic               wrap_q, wrap_d;
`ifdef CYCLIC_LAMP_BLINK_EN
   logic               phase_q, phase_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (lamp.en) begin
               state_d = S_RUN;
               idx_d   = lamp.dir ? IDX_LAST : '0;
               cnt_d   = '0;
            end
         end
         default: begin
            if (!lamp.en) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (lamp.hold) begin
               state_d = S_PAUSE;
            end else begin
               // Leaving PAUSE takes the step skipped on the edge that entered it,
               // so the lamp still totals DWELL running cycles.
               state_d = S_RUN;
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (lamp.dir) begin
                     if (idx_q == '0) begin
                        idx_d  = IDX_LAST;
                        wrap_d = 1'b1;
                     end else begin
                        idx_d = idx_q - IDX_W'(1);
                     end
                  end else begin
                     if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                     end else begin
                        idx_d = idx_q + IDX_W'(1);
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
      endcase

`ifdef CYCLIC_LAMP_BLINK_EN
      if (state_d == S_IDLE || state_q == S_IDLE)
         phase_d = 1'b1;
      else if (state_d == S_PAUSE)
         phase_d = phase_q;
      else
         phase_d = lamp.blink ? ~phase_q : 1'b1;
`endif

      light_d = '0;
      if (state_d != S_IDLE)
         light_d = N_LAMPS'(1) << idx_d;
`ifdef CYCLIC_LAMP_BLINK_EN
      light_d = light_d & {N_LAMPS{phase_d}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         light_q <= '0;
         wrap_q  <= 1'b0;
`ifdef CYCLIC_LAMP_BLINK_EN
         phase_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         light_q <= light_d;
         wrap_q  <= wrap_d;
`ifdef CYCLIC_LAMP_BLINK_EN
         phase_q <= phase_d;
`endif
      end
   end

   assign lamp.light = light_q;
   assign lamp.idx   = idx_q;
   assign lamp.wrap  = wrap_q;
endmodule

// File: tb/tb_cyclic_lamp_seq.sv
// Bench for cyclic_lamp_seq: table-driven vectors with a scoreboard queue on two instances
// (3 lamps / dwell 2 and 4 lamps / dwell 1), plus an asynchronous mid-run reset.
module tb_cyclic_lamp_seq;
   typedef struct packed {
      logic       en;
      logic       dir;
      logic       hold;
      logic [3:0] light;
      logic [1:0] idx;
      logic       wrap;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a_n, rst_b_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   vec_t tab_a1[$], tab_a2[$], tab_a3[$], tab_b[$];

   always #5 clk = ~clk;

   cyclic_lamp_seq_if #(.N_LAMPS(3)) if_a ();
   cyclic_lamp_seq_if #(.N_LAMPS(4)) if_b ();

   cyclic_lamp_seq #(.N_LAMPS(3), .DWELL(2)) dut_a (.clk(clk), .rst_n(rst_a_n), .lamp(if_a));
   cyclic_lamp_seq #(.N_LAMPS(4), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_b_n), .lamp(if_b));

   function automatic vec_t mk(bit en, bit dir, bit hold, logic [3:0] l, int i, bit w);
      vec_t r;
      r.en    = en;
      r.dir   = dir;
      r.hold  = hold;
      r.light = l;
      r.idx   = 2'(i);
      r.wrap  = w;
      return r;
   endfunction

   task automatic chk(input string tag, input int k, input logic [3:0] al,
                      input logic [1:0] ai, input logic aw, input vec_t e);
      n_tests++;
      if (al !== e.light || ai !== e.idx || aw !== e.wrap) begin
         n_fail++;
         $display("FAIL %s[%0d]: got light=%b idx=%0d wrap=%b, expected light=%b idx=%0d wrap=%b",
                  tag, k, al, ai, aw, e.light, e.idx, e.wrap);
      end
   endtask

   task automatic step(input vec_t v, input bit sel_b, input string tag, input int k);
      vec_t e;
      if (sel_b) begin
         if_b.en = v.en; if_b.dir = v.dir; if_b.hold = v.hold;
      end else begin
         if_a.en = v.en; if_a.dir = v.dir; if_a.hold = v.hold;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (sel_b) chk(tag, k, if_b.light, if_b.idx, if_b.wrap, e);
      else       chk(tag, k, {1'b0, if_a.light}, if_a.idx, if_a.wrap, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // forward revolution
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,1));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(0,0,0,4'b0000,0,0));
      // reverse revolution from IDLE
      tab_a1.push_back(mk(1,1,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,1,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,1,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,1,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,1,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,1,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,1,0,4'b0100,2,1));
      tab_a1.push_back(mk(1,1,0,4'b0100,2,0));
      tab_a1.push_back(mk(0,1,0,4'b0000,0,0));
      // hold for 5 cycles at idx=1, count=0
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      for (int i = 0; i < 5; i++) tab_a1.push_back(mk(1,0,1,4'b0010,1,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,1));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      // en=0 while lamp 1 lit, then restart forward
      tab_a1.push_back(mk(0,0,0,4'b0000,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      // dir flips: step back without wrap, then reverse across boundary
      tab_a1.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,1,0,4'b0010,1,0));
      tab_a1.push_back(mk(1,1,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,1,0,4'b0001,0,0));
      tab_a1.push_back(mk(1,1,0,4'b0100,2,1));
      // en=0 wins over hold
      tab_a1.push_back(mk(0,1,1,4'b0000,0,0));
      // run up to a wrap cycle, then reset asynchronously
      tab_a2.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a2.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a2.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a2.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a2.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a2.push_back(mk(1,0,0,4'b0100,2,0));
      tab_a2.push_back(mk(1,0,0,4'b0001,0,1));
      tab_a3.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a3.push_back(mk(1,0,0,4'b0001,0,0));
      tab_a3.push_back(mk(1,0,0,4'b0010,1,0));
      tab_a3.push_back(mk(0,0,0,4'b0000,0,0));
      // 4 lamps, dwell 1
      tab_b.push_back(mk(1,0,0,4'b0001,0,0));
      tab_b.push_back(mk(1,0,0,4'b0010,1,0));
      tab_b.push_back(mk(1,0,0,4'b0100,2,0));
      tab_b.push_back(mk(1,0,0,4'b1000,3,0));
      tab_b.push_back(mk(1,0,0,4'b0001,0,1));
      tab_b.push_back(mk(1,0,0,4'b0010,1,0));
      tab_b.push_back(mk(1,0,1,4'b0010,1,0));
      tab_b.push_back(mk(1,0,1,4'b0010,1,0));
      tab_b.push_back(mk(1,0,0,4'b0100,2,0));
      tab_b.push_back(mk(1,0,0,4'b1000,3,0));
      tab_b.push_back(mk(1,0,0,4'b0001,0,1));
      tab_b.push_back(mk(1,1,0,4'b1000,3,1));
      tab_b.push_back(mk(1,1,0,4'b0100,2,0));
      tab_b.push_back(mk(0,1,0,4'b0000,0,0));

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      if_a.en = 1'b0; if_a.dir = 1'b0; if_a.hold = 1'b0;
      if_b.en = 1'b0; if_b.dir = 1'b0; if_b.hold = 1'b0;
`ifdef CYCLIC_LAMP_BLINK_EN
      if_a.blink = 1'b0;
      if_b.blink = 1'b0;
`endif
      #3;
      chk("reset_a", 0, {1'b0, if_a.light}, if_a.idx, if_a.wrap, mk(0,0,0,4'b0000,0,0));
      chk("reset_b", 0, if_b.light, if_b.idx, if_b.wrap, mk(0,0,0,4'b0000,0,0));
      #20;
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_a", 0, {1'b0, if_a.light}, if_a.idx, if_a.wrap, mk(0,0,0,4'b0000,0,0));

      for (int k = 0; k < tab_a1.size(); k++) step(tab_a1[k], 1'b0, "seq_a", k);
      for (int k = 0; k < tab_a2.size(); k++) step(tab_a2[k], 1'b0, "pre_rst_a", k);

      #2;
      rst_a_n = 1'b0;
      #1;
      chk("async_rst_a", 0, {1'b0, if_a.light}, if_a.idx, if_a.wrap, mk(0,0,0,4'b0000,0,0));
      @(posedge clk);
      #1;
      chk("async_rst_a", 1, {1'b0, if_a.light}, if_a.idx, if_a.wrap, mk(0,0,0,4'b0000,0,0));
      #2;
      rst_a_n = 1'b1;
      for (int k = 0; k < tab_a3.size(); k++) step(tab_a3[k], 1'b0, "post_rst_a", k);

      for (int k = 0; k < tab_b.size(); k++) step(tab_b[k], 1'b1, "seq_b", k);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
